// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the control unit and the sequential multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: none; the requester must watch busy/done before issuing start.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [4:0]           opcode;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [2*WIDTH-1:0]   C;

    // Control unit side: issues operations, observes status and result.
    modport master (
        output start, opcode, A, B,
        input  busy, done, div_by_zero, C
    );

    // Arithmetic unit side.
    modport slave (
        input  start, opcode, A, B,
        output busy, done, div_by_zero, C
    );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit writing {HI,LO}.
// Latency: MUL done 33 cycles after acceptance, DIV 34, divide-by-zero 1.
// Backpressure: start is only taken in IDLE; starts while busy or in the done cycle are dropped.
module muldiv_seq #(
    parameter int         WIDTH  = 32,
    parameter logic [4:0] OP_MUL = 5'b10000,
    parameter logic [4:0] OP_DIV = 5'b01111
) (
    input  logic         clock,
    input  logic         reset_n,
    muldiv_seq_if.slave  bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [CW-1:0]       cnt;
    // Booth accumulator: {hi, lo (multiplier), q[-1]}
    logic [2*WIDTH:0]    acc;
    logic [WIDTH-1:0]    mcand;
    // Restoring divider: partial remainder, quotient/dividend shift register, divisor magnitude
    logic [WIDTH-1:0]    rem;
    logic [WIDTH-1:0]    quo;
    logic [WIDTH-1:0]    dvs;
    logic                neg_q;
    logic                neg_r;
    logic [2*WIDTH-1:0]  c_reg;
    logic                dz_reg;

    logic                accept;
    logic                is_mul;
    logic                b_zero;
    logic                busy_c;
    logic                done_c;

    logic [WIDTH:0]      hi_ext;
    logic [WIDTH:0]      m_ext;
    logic [WIDTH:0]      booth_sum;
    logic [2*WIDTH:0]    booth_nxt;

    logic [WIDTH:0]      div_shift;
    logic [WIDTH-1:0]    div_diff;
    logic                div_ge;
    logic [WIDTH-1:0]    rem_nxt;
    logic [WIDTH-1:0]    quo_nxt;

    logic [WIDTH-1:0]    q_fix;
    logic [WIDTH-1:0]    r_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Acceptance decode, next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        is_mul    = (bus.opcode == OP_MUL);
        b_zero    = (bus.B == '0);
        accept    = (state == IDLE) && bus.start &&
                    ((bus.opcode == OP_MUL) || (bus.opcode == OP_DIV));
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_nxt = MUL;
                    end else if (b_zero) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DIV;
                    end
                end
            end
            MUL: begin
                busy_c = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DIV: begin
                busy_c = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy_c    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One Booth step: add/subtract the multiplicand into a sign-extended hi, then shift right.
    // The extra hi bit keeps the most-negative multiplicand from overflowing before the shift.
    always_comb begin
        hi_ext    = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        m_ext     = {mcand[WIDTH-1], mcand};
        booth_sum = hi_ext;
        case (acc[1:0])
            2'b01:   booth_sum = hi_ext + m_ext;
            2'b10:   booth_sum = hi_ext - m_ext;
            default: booth_sum = hi_ext;
        endcase
        booth_nxt = {booth_sum, acc[WIDTH:1]};
    end

    // One restoring-division step on magnitudes, plus the final sign fix-up.
    always_comb begin
        div_shift = {rem, quo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, dvs});
        div_diff  = div_shift[WIDTH-1:0] - dvs;
        rem_nxt   = div_ge ? div_diff : div_shift[WIDTH-1:0];
        quo_nxt   = {quo[WIDTH-2:0], div_ge};
        q_fix     = neg_q ? (~quo + 1'b1) : quo;
        r_fix     = neg_r ? (~rem + 1'b1) : rem;
    end

    // Datapath: operand latch, iteration, and the result register that only moves on the done edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            c_reg  <= '0;
            dz_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        acc    <= {{WIDTH{1'b0}}, bus.B, 1'b0};
                        mcand  <= bus.A;
                        rem    <= '0;
                        quo    <= mag(bus.A);
                        dvs    <= mag(bus.B);
                        neg_q  <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        neg_r  <= bus.A[WIDTH-1];
                        dz_reg <= 1'b0;
                        if (!is_mul && b_zero) begin
                            dz_reg <= 1'b1;
                            c_reg  <= {bus.A, {WIDTH{1'b1}}};
                        end
                    end
                end
                MUL: begin
                    acc <= booth_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        c_reg <= booth_nxt[2*WIDTH:1];
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    c_reg <= {r_fix, q_fix};
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.C           = c_reg;
    assign bus.div_by_zero = dz_reg;

endmodule
